// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - FSM state encoding (S_IDLE / S_SHIFT / S_DONE)
//   - default binary width and digit count
//   - double-dabble add-3 threshold and increment
// ---------------------------------------------------------------------------
package bcd_pkg;

    // Defaults match the 16-bit divider upstream; 5 digits cover 0..65535.
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    // A digit >= 5 would become >= 10 after the next doubling, so it is
    // pre-corrected by +3 (the classic shift-and-add-3 rule).
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational per-digit double-dabble correction.
// Ports:
//   digit      in  4  current BCD digit
//   adj_digit  out 4  digit + 3 when digit >= 5, else digit unchanged
// The result is kept to 4 bits; no carry ever leaves a digit because any
// legal working digit (0..9) maps to at most 12.
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj_digit
);

    assign adj_digit = (digit >= ADJ_THRESH) ? (digit + ADJ_ADD) : digit;

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-packed-BCD converter (double dabble, one bit per clk).
// Sits after the sequential divider; the divider's done pulse can drive start.
//
// Parameters:
//   WIDTH   binary input width                  (default 16)
//   DIGITS  number of BCD digits, needs 10^DIGITS > 2^WIDTH - 1 (default 5)
//
// Ports:
//   clk     in   1          rising-edge clock
//   rst_n   in   1          asynchronous active-low reset
//   start   in   1          conversion request, only honoured in IDLE
//   bin     in   WIDTH      unsigned value, captured on the accepting edge
//   busy    out  1          high from accept edge until the result edge
//   done    out  1          one-cycle pulse when bcd is updated
//   bcd     out  4*DIGITS   packed BCD result (digit 0 in [3:0]), held
//
// Timing: accept at edge 0, shifts on edges 1..WIDTH, result/done on edge
// WIDTH+1, done clears on edge WIDTH+2 (where a held start is re-accepted).
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  sh_bin;
    logic [BW-1:0]     sh_bcd;
    logic [BW-1:0]     adj_bcd;
    logic [CW-1:0]     cnt;

    // Add-3 correction network applied to every working digit in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit     (sh_bcd[4*g +: 4]),
            .adj_digit (adj_bcd[4*g +: 4])
        );
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // cnt counts remaining shifts; 1 means this edge is the last.
                if (cnt == CW'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sh_bin <= '0;
            sh_bcd <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_bin <= bin;
                        sh_bcd <= '0;
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Adjust first, then shift the binary MSB into the BCD LSB.
                    // The final shift is not followed by another adjust, so the
                    // value captured in S_DONE is already in 0..9 per digit.
                    sh_bcd <= {adj_bcd[BW-2:0], sh_bin[WIDTH-1]};
                    sh_bin <= {sh_bin[WIDTH-2:0], 1'b0};
                    cnt    <= cnt - CW'(1);
                end
                S_DONE: begin
                    bcd  <= sh_bcd;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed bench for bin2bcd_seq. A cycle-level reference model derived from
// plain decimal arithmetic runs alongside the DUT and is compared every cycle
// out of reset; directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin   = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal digits by repeated division.
    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: m_k = edges since acceptance, -1 when idle.
    int          m_k;
    int unsigned m_val;
    logic        m_busy;
    logic        m_done;
    logic [19:0] m_bcd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k    <= -1;
            m_val  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_bcd  <= '0;
        end else if (m_k < 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_k    <= 0;
                m_val  <= int'(bin);
                m_busy <= 1'b1;
            end
        end else if (m_k == WIDTH) begin
            m_bcd  <= to_bcd(m_val);
            m_done <= 1'b1;
            m_busy <= 1'b0;
            m_k    <= -1;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_bcd",  32'(bcd),  32'(m_bcd));
        end
    end

    // Pulse start for one cycle with value v, then scramble bin; returns the
    // number of edges from accept until done is observed (bounded).
    task automatic conv(input logic [15:0] v, output int lat);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = 16'($urandom);
        lat   = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_done(input int ncyc, output int nd);
        nd = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nd;
        int nbusy_low;
        int prev;
        int n;

        // Reset hold.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  32'(bcd),  32'h00000);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        count_done(4, nd);
        chk("idle_no_done", 32'(nd), 32'd0);
        chk("idle_bcd", 32'(bcd), 32'h00000);

        // Pin the reference model itself.
        chk("model_870",   32'(to_bcd(870)),   32'h00870);
        chk("model_65535", 32'(to_bcd(65535)), 32'h65535);

        // Divider result and remainder.
        conv(16'd870, lat);
        chk("lat_870", 32'(lat), 32'd17);
        chk("bcd_870", 32'(bcd), 32'h00870);
        conv(16'd10, lat);
        chk("lat_10", 32'(lat), 32'd17);
        chk("bcd_10", 32'(bcd), 32'h00010);

        // Extremes.
        conv(16'd0, lat);
        chk("lat_0", 32'(lat), 32'd17);
        chk("bcd_0", 32'(bcd), 32'h00000);
        conv(16'd65535, lat);
        chk("bcd_65535", 32'(bcd), 32'h65535);
        conv(16'd9999, lat);
        chk("bcd_9999", 32'(bcd), 32'h09999);

        // Busy protection: a second start mid-conversion is ignored.
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd1234;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        bin   = 16'd4321;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        nbusy_low = 0;
        while (!done && n < 40) begin
            if (!busy) nbusy_low++;
            @(negedge clk);
            n++;
        end
        chk("busy_prot_timeout", 32'(n < 40), 32'd1);
        chk("busy_prot_busy_high", 32'(nbusy_low), 32'd0);
        chk("busy_prot_bcd", 32'(bcd), 32'h01234);
        count_done(25, nd);
        chk("busy_prot_no_second", 32'(nd), 32'd0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bcd",  32'(bcd),  32'h00000);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        count_done(25, nd);
        chk("midrst_no_done", 32'(nd), 32'd0);
        chk("midrst_bcd_hold", 32'(bcd), 32'h00000);
        conv(16'd42, lat);
        chk("lat_42", 32'(lat), 32'd17);
        chk("bcd_42", 32'(bcd), 32'h00042);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd1;
        prev  = 0;
        for (int i = 1; i <= 3; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 40);
            chk("b2b_timeout", 32'(n < 40), 32'd1);
            chk("b2b_bcd", 32'(bcd), 32'(i));
            if (i > 1) chk("b2b_gap", 32'(cyc - prev), 32'd18);
            prev = cyc;
            if (i < 3) bin = 16'(i + 1);
            else       start = 1'b0;
        end
        count_done(25, nd);
        chk("b2b_no_fourth", 32'(nd), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bin2bcd_seq
